// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and
// request legality helpers used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } lsu_state_e;

  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return !(funct3 == SB || funct3 == SH || funct3 == SW);
    end
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  // funct3[1:0] is the access size for every legal code: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: extracts and extends load data from a
// memory word, and merges a sub-word store into the old memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b    = load_word[{offset, 3'b000} +: 8];
    lane_h    = load_word[{offset[1], 4'b0000} +: 16];
    load_data = load_word;
    case (funct3)
      LB:      load_data = {{24{lane_b[7]}}, lane_b};
      LH:      load_data = {{16{lane_h[15]}}, lane_h};
      LBU:     load_data = {24'h000000, lane_b};
      LHU:     load_data = {16'h0000, lane_h};
      default: load_data = load_word;
    endcase
  end

  // Store funct3 codes only; SW replaces the whole word.
  always_comb begin
    merged_word = old_word;
    case (funct3)
      SB:      merged_word[{offset, 3'b000} +: 8] = wdata[7:0];
      SH:      merged_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Non-pipelined RISC-V load/store unit in front of a word-wide data_memory.
// Optional performance counters are enabled with `define LSU_PERF_CNT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ENTRY_COUNT = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_readAddr,
  output logic [ADDR_WIDTH-1:0] mem_writeAddr,
  output logic [31:0]           mem_writeData,
  output logic                  mem_writeEn,
  input  logic [31:0]           mem_readData
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_loads,
  output logic [31:0]           perf_stores,
  output logic [31:0]           perf_errors
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ENTRY_LIMIT = ADDR_WIDTH'(ENTRY_COUNT);

  lsu_state_e              state, state_next;
  logic                    accept;
  logic                    req_err;
  logic                    we_q;
  logic [2:0]              funct3_q;
  logic [1:0]              offset_q;
  logic [31:0]             wdata_q;
  logic [ADDR_WIDTH-3:0]   index_q;
  logic [31:0]             merged_q;
  logic [31:0]             load_data;
  logic [31:0]             merged_word;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  assign req_err = funct3_illegal(req_we, req_funct3)
                || misaligned(req_funct3, req_addr[1:0])
                || ({2'b00, req_addr[ADDR_WIDTH-1:2]} >= ENTRY_LIMIT);

  assign mem_readAddr  = {2'b00, index_q};
  assign mem_writeAddr = mem_readAddr;

  lsu_align u_align (
    .load_word   (mem_readData),
    .old_word    (mem_readData),
    .wdata       (wdata_q),
    .offset      (offset_q),
    .funct3      (funct3_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_next    = state;
    mem_writeEn   = 1'b0;
    mem_writeData = 32'h0;
    case (state)
      IDLE: begin
        if (accept) state_next = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (we_q && funct3_q != SW) begin
          state_next = WRITE;
        end else begin
          state_next = RESP;
          if (we_q) begin
            mem_writeEn   = 1'b1;
            mem_writeData = wdata_q;
          end
        end
      end
      WRITE: begin
        state_next    = RESP;
        mem_writeEn   = 1'b1;
        mem_writeData = merged_q;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accept / ACCESS stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      offset_q  <= 2'b00;
      wdata_q   <= 32'h0;
      index_q   <= '0;
      merged_q  <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q      <= req_we;
        funct3_q  <= req_funct3;
        offset_q  <= req_addr[1:0];
        wdata_q   <= req_wdata;
        index_q   <= req_addr[ADDR_WIDTH-1:2];
        rsp_err   <= req_err;
        rsp_rdata <= 32'h0;
      end
      if (state == ACCESS) begin
        merged_q <= merged_word;
        if (!we_q) rsp_rdata <= load_data;
      end
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= 32'h0;
      perf_stores <= 32'h0;
      perf_errors <= 32'h0;
    end else if (state == RESP) begin
      if (rsp_err)   perf_errors <= perf_errors + 32'd1;
      else if (we_q) perf_stores <= perf_stores + 32'd1;
      else           perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule
